regfile_2p_param: RTL and testbench

- Parametrised successor to the team's 8x16 single-address register file.
- Separate write and read addresses, so a write and a read can occur in the same cycle.
- Adds read-during-write bypass, a per-address write-protect mask, an optional read pipeline stage, error flags and a parametrised tap bus.
- Sits between the system controller / UART command decoder and the ALU/UART/clock-divider config consumers; the taps replace hard-wired REG0..REG3.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_rd_pipe.sv | 31 +++
 rtl/regfile_2p_param.sv | 124 ++++++++++++
 tb/tb_regfile_2p_param.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised two-port register file.
package regfile_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_ADDR_WIDTH = 4;

   // Power-on contents of the config registers read by the UART and clock divider
   localparam logic [7:0] UART_CFG_RST = 8'b1000_0001;
   localparam logic [7:0] CLK_DIV_RST  = 8'd32;

   // Register i resets to slice [i*WIDTH +: WIDTH]; reg2 = UART config, reg3 = clock divider
   localparam logic [DEF_DEPTH*DEF_WIDTH-1:0] RST_VALS_DEFAULT =
      {{((DEF_DEPTH - 4) * DEF_WIDTH){1'b0}}, CLK_DIV_RST, UART_CFG_RST, 8'h00, 8'h00};

   // True when an address names a physically present register
   function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
      return addr < depth;
   endfunction

endpackage

// File: rtl/regfile_rd_pipe.sv
// Optional extra read stage: delays {data, valid, err} by one cycle while
// keeping the data output stable between read results.
module regfile_rd_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   input  logic             err_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             err_out
);

   // Pulses pass straight through one register; data only moves when a new result arrives
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_out  <= '0;
         valid_out <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         valid_out <= valid_in;
         err_out   <= err_in;
         if (valid_in) begin
            data_out <= data_in;
         end
      end
   end

endmodule

// File: rtl/regfile_2p_param.sv
// Parametrised register file with independent write and read ports,
// write-first bypass, per-register write protection, optional read pipeline,
// error pulses and a continuous tap bus for the low registers.
module regfile_2p_param
   import regfile_pkg::*;
#(
   parameter int                       WIDTH      = DEF_WIDTH,
   parameter int                       DEPTH      = DEF_DEPTH,
   parameter int                       ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                       RD_LAT     = 1,
   parameter int                       NUM_TAP    = 4,
   parameter logic [DEPTH-1:0]         WP_MASK    = '0,
   parameter logic [DEPTH*WIDTH-1:0]   RST_VALS   = (DEPTH*WIDTH)'(RST_VALS_DEFAULT)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     WrEn,
   input  logic [ADDR_WIDTH-1:0]    WrAddr,
   input  logic [WIDTH-1:0]         WrData,
   input  logic                     RdEn,
   input  logic [ADDR_WIDTH-1:0]    RdAddr,
   output logic [WIDTH-1:0]         RdData,
   output logic                     RdData_Valid,
   output logic                     WrErr,
   output logic                     RdErr,
   output logic [NUM_TAP*WIDTH-1:0] Taps
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_in_range;
   logic             wr_protected;
   logic             wr_ok;
   logic             rd_in_range;
   logic [WIDTH-1:0] rd_mem;
   logic [WIDTH-1:0] rd_word;

   logic [WIDTH-1:0] s1_data;
   logic             s1_valid;
   logic             s1_err;
   logic             wr_err_q;

   // Decode the write request and form the word a read would return this cycle
   always_comb begin
      wr_in_range  = addr_in_range(32'(WrAddr), DEPTH);
      rd_in_range  = addr_in_range(32'(RdAddr), DEPTH);
      wr_protected = 1'b0;
      rd_mem       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (WrAddr == ADDR_WIDTH'(i)) begin
            wr_protected = WP_MASK[i];
         end
         if (RdAddr == ADDR_WIDTH'(i)) begin
            rd_mem = mem[i];
         end
      end
      wr_ok = WrEn && wr_in_range && !wr_protected;
      if (!rd_in_range) begin
         rd_word = '0;
      end else if (wr_ok && (WrAddr == RdAddr)) begin
         rd_word = WrData;
      end else begin
         rd_word = rd_mem;
      end
   end

   // Storage: reset to the configured power-on values, update only on accepted writes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RST_VALS[i*WIDTH +: WIDTH];
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (WrAddr == ADDR_WIDTH'(i))) begin
               mem[i] <= WrData;
            end
         end
      end
   end

   // First read stage and the write-reject pulse; read data holds between requests
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         s1_valid <= RdEn;
         s1_err   <= RdEn && !rd_in_range;
         wr_err_q <= WrEn && !wr_ok;
         if (RdEn) begin
            s1_data <= rd_word;
         end
      end
   end

   assign WrErr = wr_err_q;

   if (RD_LAT == 2) begin : g_rd_pipe
      regfile_rd_pipe #(
         .WIDTH(WIDTH)
      ) u_rd_pipe (
         .CLK      (CLK),
         .RST      (RST),
         .data_in  (s1_data),
         .valid_in (s1_valid),
         .err_in   (s1_err),
         .data_out (RdData),
         .valid_out(RdData_Valid),
         .err_out  (RdErr)
      );
   end else begin : g_rd_direct
      assign RdData       = s1_data;
      assign RdData_Valid = s1_valid;
      assign RdErr        = s1_err;
   end

   for (genvar t = 0; t < NUM_TAP; t++) begin : g_taps
      assign Taps[t*WIDTH +: WIDTH] = mem[t];
   end

endmodule

// File: tb/tb_regfile_2p_param.sv
// Bench for regfile_2p_param: two instances share one stimulus bus.
//   dut 0: defaults (16 regs, RD_LAT=1, no protection)
//   dut 1: 12 regs, RD_LAT=2, register 9 write-protected
module tb_regfile_2p_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       rd_en = 1'b0;
   logic [3:0] rd_addr = '0;

   logic [7:0]  rd_data  [2];
   logic        rd_valid [2];
   logic        rd_err   [2];
   logic        wr_err   [2];
   logic [31:0] taps     [2];

   int checks = 0;
   int fails  = 0;

   // Reference model state: register contents and expected outputs per instance
   logic [7:0] m_mem   [2][16];
   logic [7:0] m_data  [2];
   logic       m_valid [2];
   logic       m_rerr  [2];
   logic       m_werr  [2];
   logic [7:0] p_data  [2];
   logic       p_valid [2];
   logic       p_err   [2];

   always #5 clk = ~clk;

   regfile_2p_param u_dut0 (
      .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
      .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data[0]), .RdData_Valid(rd_valid[0]),
      .WrErr(wr_err[0]), .RdErr(rd_err[0]), .Taps(taps[0])
   );

   regfile_2p_param #(
      .DEPTH(12), .ADDR_WIDTH(4), .RD_LAT(2), .NUM_TAP(4), .WP_MASK(12'b0010_0000_0000)
   ) u_dut1 (
      .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
      .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data[1]), .RdData_Valid(rd_valid[1]),
      .WrErr(wr_err[1]), .RdErr(rd_err[1]), .Taps(taps[1])
   );

   function automatic int depth_of(int k);
      return (k == 0) ? 16 : 12;
   endfunction

   function automatic int lat_of(int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic bit is_protected(int k, int a);
      return (k == 1) && (a == 9);
   endfunction

   function automatic logic [31:0] model_taps(int k);
      return {m_mem[k][3], m_mem[k][2], m_mem[k][1], m_mem[k][0]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            m_mem[k][i] = (i == 2) ? 8'h81 : (i == 3) ? 8'h20 : 8'h00;
         end
         m_data[k] = 8'h00; m_valid[k] = 1'b0; m_rerr[k] = 1'b0; m_werr[k] = 1'b0;
         p_data[k] = 8'h00; p_valid[k] = 1'b0; p_err[k] = 1'b0;
      end
   endtask

   // Apply one clock edge's worth of requests to the model
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit         ok;
         bit         nv, ne, ov, oe;
         logic [7:0] nd, od;
         ok = wr_en && (int'(wr_addr) < depth_of(k)) && !is_protected(k, int'(wr_addr));
         nv = rd_en;
         ne = rd_en && (int'(rd_addr) >= depth_of(k));
         if (ne) nd = 8'h00;
         else if (ok && wr_addr == rd_addr) nd = wr_data;
         else nd = m_mem[k][rd_addr];
         if (lat_of(k) == 2) begin
            ov = p_valid[k]; od = p_data[k]; oe = p_err[k];
            p_valid[k] = nv; p_data[k] = nd; p_err[k] = ne;
         end else begin
            ov = nv; od = nd; oe = ne;
         end
         m_valid[k] = ov;
         m_rerr[k]  = ov && oe;
         if (ov) m_data[k] = od;
         m_werr[k] = wr_en && !ok;
         if (ok) m_mem[k][wr_addr] = wr_data;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (taps[k] !== 32'h2081_0000) begin
            fails++; $display("[TB] FAIL reset_taps dut%0d: got %h expected %h", k, taps[k], 32'h2081_0000);
         end
         checks++;
         if (rd_data[k] !== 8'h00 || rd_valid[k] !== 1'b0 || wr_err[k] !== 1'b0 || rd_err[k] !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_outputs dut%0d: got data=%h v=%b we=%b re=%b expected 00 0 0 0",
                              k, rd_data[k], rd_valid[k], wr_err[k], rd_err[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      rd_en = 1'b1; rd_addr = 4'd5;
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'h00) begin
         fails++; $display("[TB] FAIL reset_read5 dut0: got v=%b data=%h expected 1 00", rd_valid[0], rd_data[0]);
      end
      checks++;
      if (rd_valid[1] !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_read5_early dut1: got v=%b expected 0", rd_valid[1]);
      end
      step();
      checks++;
      if (rd_valid[1] !== 1'b1 || rd_data[1] !== 8'h00 || rd_valid[0] !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_read5 dut1: got v=%b data=%h dut0 v=%b expected 1 00 0",
                           rd_valid[1], rd_data[1], rd_valid[0]);
      end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_addr = 4'd7;
      step();
      rd_en = 1'b0;
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'hA5) begin
         fails++; $display("[TB] FAIL wr_rd dut0: got v=%b data=%h expected 1 a5", rd_valid[0], rd_data[0]);
      end
      step();
      checks++;
      if (rd_valid[0] !== 1'b0 || rd_data[0] !== 8'hA5) begin
         fails++; $display("[TB] FAIL wr_rd_hold dut0: got v=%b data=%h expected 0 a5", rd_valid[0], rd_data[0]);
      end
      checks++;
      if (rd_valid[1] !== 1'b1 || rd_data[1] !== 8'hA5) begin
         fails++; $display("[TB] FAIL wr_rd dut1: got v=%b data=%h expected 1 a5", rd_valid[1], rd_data[1]);
      end
      step();
      checks++;
      if (rd_valid[1] !== 1'b0) begin
         fails++; $display("[TB] FAIL wr_rd_pulse dut1: got v=%b expected 0", rd_valid[1]);
      end
   endtask

   task automatic test_same_addr();
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C;
      rd_en = 1'b1; rd_addr = 4'd9;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      checks++;
      if (rd_valid[0] !== 1'b1 || rd_data[0] !== 8'h3C || wr_err[0] !== 1'b0) begin
         fails++; $display("[TB] FAIL bypass dut0: got v=%b data=%h we=%b expected 1 3c 0",
                           rd_valid[0], rd_data[0], wr_err[0]);
      end
      checks++;
      if (wr_err[1] !== 1'b1) begin
         fails++; $display("[TB] FAIL protect_wrerr dut1: got %b expected 1", wr_err[1]);
      end
      step();
      checks++;
      if (rd_valid[1] !== 1'b1 || rd_data[1] !== 8'h00 || wr_err[1] !== 1'b0) begin
         fails++; $display("[TB] FAIL protect_nobypass dut1: got v=%b data=%h we=%b expected 1 00 0",
                           rd_valid[1], rd_data[1], wr_err[1]);
      end
   endtask

   task automatic test_streaming();
      logic [7:0] tbl [4];
      tbl = '{8'h00, 8'h00, 8'h81, 8'h20};
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            rd_en = 1'b1; rd_addr = 4'(c);
         end else begin
            rd_en = 1'b0;
         end
         step();
         checks++;
         if (rd_valid[1] !== (c >= 1 && c <= 4)) begin
            fails++; $display("[TB] FAIL stream_valid dut1 c%0d: got %b expected %b", c, rd_valid[1], (c >= 1 && c <= 4));
         end
         if (c >= 1 && c <= 4) begin
            checks++;
            if (rd_data[1] !== tbl[c-1]) begin
               fails++; $display("[TB] FAIL stream_data dut1 c%0d: got %h expected %h", c, rd_data[1], tbl[c-1]);
            end
         end
         if (c <= 3) begin
            checks++;
            if (rd_valid[0] !== 1'b1 || rd_data[0] !== tbl[c]) begin
               fails++; $display("[TB] FAIL stream dut0 c%0d: got v=%b data=%h expected 1 %h", c, rd_valid[0], rd_data[0], tbl[c]);
            end
         end
      end
   endtask

   task automatic test_errors();
      wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'hEE;
      step();
      wr_en = 1'b0;
      checks++;
      if (wr_err[1] !== 1'b1 || wr_err[0] !== 1'b0) begin
         fails++; $display("[TB] FAIL wr_range: got dut1=%b dut0=%b expected 1 0", wr_err[1], wr_err[0]);
      end
      checks++;
      if (taps[1] !== 32'h2081_0000) begin
         fails++; $display("[TB] FAIL wr_range_taps dut1: got %h expected %h", taps[1], 32'h2081_0000);
      end
      rd_en = 1'b1; rd_addr = 4'd14;
      step();
      rd_en = 1'b0;
      checks++;
      if (wr_err[1] !== 1'b0 || rd_err[0] !== 1'b0) begin
         fails++; $display("[TB] FAIL err_pulse: got dut1 we=%b dut0 re=%b expected 0 0", wr_err[1], rd_err[0]);
      end
      step();
      checks++;
      if (rd_valid[1] !== 1'b1 || rd_err[1] !== 1'b1 || rd_data[1] !== 8'h00) begin
         fails++; $display("[TB] FAIL rd_range dut1: got v=%b re=%b data=%h expected 1 1 00",
                           rd_valid[1], rd_err[1], rd_data[1]);
      end
      step();
      checks++;
      if (rd_err[1] !== 1'b0 || rd_valid[1] !== 1'b0) begin
         fails++; $display("[TB] FAIL rd_range_pulse dut1: got re=%b v=%b expected 0 0", rd_err[1], rd_valid[1]);
      end
   endtask

   task automatic test_reset_mid_read();
      rd_en = 1'b1; rd_addr = 4'd2;
      step();
      rd_en = 1'b0;
      #3 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (rd_valid[1] !== 1'b0 || rd_data[1] !== 8'h00 || rd_valid[0] !== 1'b0 || rd_data[0] !== 8'h00) begin
         fails++; $display("[TB] FAIL midread_reset: got dut1 v=%b d=%h dut0 v=%b d=%h expected 0 00 0 00",
                           rd_valid[1], rd_data[1], rd_valid[0], rd_data[0]);
      end
      @(posedge clk);
      #4 rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (rd_valid[1] !== 1'b0 || rd_data[1] !== 8'h00 || rd_err[1] !== 1'b0) begin
            fails++; $display("[TB] FAIL midread_release dut1 c%0d: got v=%b d=%h re=%b expected 0 00 0",
                              c, rd_valid[1], rd_data[1], rd_err[1]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = 4'($urandom_range(0, 15));
         wr_data = 8'($urandom);
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
         step();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_valid[k] !== m_valid[k] || rd_data[k] !== m_data[k] || rd_err[k] !== m_rerr[k] || wr_err[k] !== m_werr[k]) begin
               fails++; $display("[TB] FAIL random_rd dut%0d n%0d: got v=%b d=%h re=%b we=%b expected %b %h %b %b",
                                 k, n, rd_valid[k], rd_data[k], rd_err[k], wr_err[k],
                                 m_valid[k], m_data[k], m_rerr[k], m_werr[k]);
            end
            checks++;
            if (taps[k] !== model_taps(k)) begin
               fails++; $display("[TB] FAIL random_taps dut%0d n%0d: got %h expected %h", k, n, taps[k], model_taps(k));
            end
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      model_reset();
      #12 rst = 1'b0;
      test_reset();
      test_write_read();
      test_same_addr();
      test_streaming();
      test_errors();
      test_reset_mid_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
